// File: rtl/pipeline_types.sv
// Shared types and default timing for the WS2812 serial encoder.
//   enc_state_t : encoder FSM state encoding
//   C_T0H/C_T1H : default high-phase lengths for '0'/'1' bits (clocks @ 50 MHz)
//   C_BIT       : default bit period (clocks)
//   C_TRESET    : default latch low period (clocks)
//   max_int     : elaboration helper for sizing the shared phase counter
package pipeline_types;

  typedef enum logic [1:0] {
    IDLE,
    SEND_HIGH,
    SEND_LOW,
    LATCH
  } enc_state_t;

  localparam int C_T0H    = 20;
  localparam int C_T1H    = 40;
  localparam int C_BIT    = 63;
  localparam int C_TRESET = 2500;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_phase_timer.sv
// Loadable down-counter shared by the bit phases and the latch period.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val this edge (takes priority over counting)
//   load_val   : phase length minus one
//   tc         : terminal count, high while the count is zero (last phase cycle)
module ws2812_phase_timer #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)               count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - 1'b1;
  end

  assign tc = (count == '0);

endmodule

// File: rtl/ws2812_encoder.sv
// WS2812 single-wire encoder: serialises 24-bit pixel words MSB first as
// high/low pulse pairs, then holds the line low for the latch period.
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_pixel_data    : 24-bit pixel word
//   i_pixel_valid   : word offered; accepted when valid & ready at an edge
//   o_pixel_ready   : high in IDLE and in the last cycle of bit 0
//   o_dout          : registered serial line to the first LED
//   o_busy          : high whenever the FSM is not in IDLE
//   o_frame_done    : one-cycle pulse as the latch period ends
module ws2812_encoder
  import pipeline_types::*;
#(
  parameter int T0H_CYCLES    = C_T0H,
  parameter int T1H_CYCLES    = C_T1H,
  parameter int BIT_CYCLES    = C_BIT,
  parameter int TRESET_CYCLES = C_TRESET
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [23:0] i_pixel_data,
  input  logic        i_pixel_valid,
  output logic        o_pixel_ready,
  output logic        o_dout,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam int CNT_W = $clog2(max_int(BIT_CYCLES, TRESET_CYCLES) + 1);

  generate
    if (!(T0H_CYCLES >= 1 && T0H_CYCLES < T1H_CYCLES &&
          T1H_CYCLES < BIT_CYCLES && TRESET_CYCLES >= 1)) begin : g_param_check
      $error("ws2812_encoder: need 1 <= T0H < T1H < BIT and TRESET >= 1");
    end
  endgenerate

  // Timer load values are length-1 so tc marks the final cycle of a phase.
  function automatic logic [CNT_W-1:0] high_cnt(input logic b);
    return b ? CNT_W'(T1H_CYCLES - 1) : CNT_W'(T0H_CYCLES - 1);
  endfunction

  function automatic logic [CNT_W-1:0] low_cnt(input logic b);
    return b ? CNT_W'(BIT_CYCLES - T1H_CYCLES - 1)
             : CNT_W'(BIT_CYCLES - T0H_CYCLES - 1);
  endfunction

  enc_state_t       state, state_nxt;
  logic [23:0]      shreg;
  logic [4:0]       bit_idx;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tc;
  logic             load_word;
  logic             shift_bit;
  logic             rdy;
  logic             dout;
  logic             frame_done;

  ws2812_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (i_clk),
    .reset    (i_reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    load_word = 1'b0;
    shift_bit = 1'b0;
    rdy       = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (i_pixel_valid) begin
          load_word = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = high_cnt(i_pixel_data[23]);
          state_nxt = SEND_HIGH;
        end
      end
      SEND_HIGH: begin
        if (tc) begin
          tmr_load  = 1'b1;
          tmr_val   = low_cnt(shreg[23]);
          state_nxt = SEND_LOW;
        end
      end
      SEND_LOW: begin
        if (tc) begin
          if (bit_idx == 5'd0) begin
            // Last cycle of the word: a waiting sender continues with no gap.
            rdy = 1'b1;
            if (i_pixel_valid) begin
              load_word = 1'b1;
              tmr_load  = 1'b1;
              tmr_val   = high_cnt(i_pixel_data[23]);
              state_nxt = SEND_HIGH;
            end else begin
              tmr_load  = 1'b1;
              tmr_val   = CNT_W'(TRESET_CYCLES - 1);
              state_nxt = LATCH;
            end
          end else begin
            // Next bit is shreg[22] until the shift lands this edge.
            shift_bit = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = high_cnt(shreg[22]);
            state_nxt = SEND_HIGH;
          end
        end
      end
      LATCH: begin
        if (tc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shreg      <= '0;
      bit_idx    <= '0;
      dout       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // Line is high exactly for the cycles spent in SEND_HIGH.
      dout       <= (state_nxt == SEND_HIGH);
      frame_done <= (state == LATCH) && tc;
      if (load_word) begin
        shreg   <= i_pixel_data;
        bit_idx <= 5'd23;
      end else if (shift_bit) begin
        shreg   <= {shreg[22:0], 1'b0};
        bit_idx <= bit_idx - 5'd1;
      end
    end
  end

  assign o_pixel_ready = rdy && !i_reset;
  assign o_dout        = dout;
  assign o_busy        = (state != IDLE);
  assign o_frame_done  = frame_done;

endmodule

// File: doc/ws2812_encoder.md
WS2812_ENCODER -- requirements
Module: ws2812_encoder

Interface
REQ-001 SHALL have parameter T0H_CYCLES, default 20, meaning the high-phase length in clocks for a '0' bit (0.4 us at 50 MHz).
REQ-002 SHALL have parameter T1H_CYCLES, default 40, meaning the high-phase length in clocks for a '1' bit (0.8 us).
REQ-003 SHALL have parameter BIT_CYCLES, default 63, meaning the total bit period in clocks (1.25 us).
REQ-004 SHALL have parameter TRESET_CYCLES, default 2500, meaning the latch low period in clocks (50 us).
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-006 SHALL have port i_reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port i_pixel_data, input, 24 bits: pixel word, transmitted MSB first; G/R/B ordering is the caller's concern.
REQ-008 SHALL have port i_pixel_valid, input, 1 bit: pixel word offered.
REQ-009 SHALL have port o_pixel_ready, output, 1 bit: encoder accepts a word when valid&ready is high at a rising edge.
REQ-010 SHALL have port o_dout, output, 1 bit: registered serial line to the first LED.
REQ-011 SHALL have port o_busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port o_frame_done, output, 1 bit: one-cycle pulse when the latch period completes.

Function
REQ-013 SHALL implement the FSM states IDLE, SEND_HIGH, SEND_LOW and LATCH, stored in enc_state_t.
REQ-014 SHALL drive o_pixel_ready high in IDLE and in the final cycle of SEND_LOW for bit 0; elsewhere it SHALL be low, and it SHALL never depend combinationally on i_pixel_valid.
REQ-015 On handshake, SHALL load i_pixel_data into a 24-bit shift register, set the bit index to 23, and enter SEND_HIGH; o_dout SHALL go high on the following edge.
REQ-016 In SEND_HIGH, SHALL hold o_dout=1 for T1H_CYCLES if the current bit is 1, else for T0H_CYCLES, then enter SEND_LOW.
REQ-017 In SEND_LOW, SHALL hold o_dout=0 for the remainder of the period, so that the high and low phases total exactly BIT_CYCLES; it SHALL then shift left and decrement the bit index.
REQ-018 A pixel SHALL occupy exactly 24*BIT_CYCLES clocks on o_dout.
REQ-019 If a handshake occurs at the end of bit 0, the next pixel's bit 23 SHALL start on the next clock with zero gap.
REQ-020 If no handshake occurs at the end of bit 0, SHALL enter LATCH, holding o_dout=0 and ready=0 for TRESET_CYCLES, then pulse o_frame_done for one cycle while entering IDLE.
REQ-021 i_pixel_valid asserted during LATCH SHALL be ignored until IDLE; the word SHALL be held by the sender.
REQ-022 The phase counter width SHALL be $clog2(max(BIT_CYCLES,TRESET_CYCLES)+1) bits, and it SHALL be shared by the bit and latch phases.
REQ-023 SHALL enforce T0H_CYCLES < T1H_CYCLES < BIT_CYCLES and TRESET_CYCLES >= 1 via an elaboration-time assertion.

Reset
REQ-024 While i_reset is high at a rising edge: state=IDLE, o_dout=0, o_busy=0, o_frame_done=0, counter=0, shift register=0.
REQ-025 Reset mid-pixel or mid-latch SHALL discard the in-flight word, SHALL NOT pulse o_frame_done, and SHALL drive o_dout low from the next edge.
REQ-026 o_pixel_ready SHALL be 0 during the reset cycle and 1 in the first cycle after reset deasserts.

Structure
REQ-027 enc_state_t and the default timing localparams (C_T0H, C_T1H, C_BIT, C_TRESET) SHALL live in pipeline_types.
REQ-028 One sub-module, ws2812_phase_timer, SHALL be used: a loadable down-counter with a terminal-count output, instantiated once.
REQ-029 Total RTL SHALL be roughly 150-250 lines.

Verification (sim params T0H=2, T1H=4, BIT=6, TRESET=10)
REQ-030 Send pixel 24'hA50000 with valid held one cycle -> o_dout shows bit 23 high for 4 clocks then low for 2, bit 22 high for 2 then low for 4; pixel length 144 clocks; LATCH lasts 10 clocks; o_frame_done pulses once.
REQ-031 Send two back-to-back pixels 24'hFFFFFF and 24'h000000 -> second handshake occurs in the final cycle of the first; no idle cycle between them; 288 clocks of data precede LATCH.
REQ-032 Assert valid during LATCH with 24'h123456 -> ready stays 0; the word is accepted in the first IDLE cycle; o_frame_done precedes the new transmission.
REQ-033 Assert i_reset at bit 10 of pixel 24'hFFFFFF -> o_dout=0 next edge; no o_frame_done; o_pixel_ready=1 one cycle after release.
REQ-034 Run a random stream of 50 pixels with random valid gaps -> a scoreboard decoding o_dout by high-phase length recovers every word in order, and o_frame_done count equals the number of gaps.
